// File: rtl/washer_plant_model.sv
// Sensor-side plant model for the washer controller: water level, phase timers and safety monitor.
// Sensor outputs are registered (1 edge from actuator to sensor); always ready, no backpressure.
module washer_plant_model #(
  parameter int LEVEL_MAX   = 8,
  parameter int DET_CYCLES  = 3,
  parameter int WASH_CYCLES = 10,
  parameter int SPIN_CYCLES = 6,
  parameter int TW          = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_doorlock,
  input  logic       i_fillvalve_on,
  input  logic       i_drainvalve_on,
  input  logic       i_motor_on,
  input  logic       i_soap_wash,
  input  logic       i_water_wash,
  output logic       o_filled,
  output logic       o_drained,
  output logic       o_detergent,
  output logic       o_cycletime_out,
  output logic       o_spintime_out,
  output logic [2:0] o_phase,
  output logic       o_fault
);

  localparam logic [TW-1:0] L_MAX  = TW'(LEVEL_MAX);
  localparam logic [TW-1:0] D_MAX  = TW'(DET_CYCLES);
  localparam logic [TW-1:0] W_MAX  = TW'(WASH_CYCLES);
  localparam logic [TW-1:0] S_MAX  = TW'(SPIN_CYCLES);

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_SOAP  = 3'd2,
    PH_WASH  = 3'd3,
    PH_DRAIN = 3'd4,
    PH_SPIN  = 3'd5,
    PH_FAULT = 3'd7
  } phase_t;

  logic [TW-1:0] r_level, r_det, r_wash, r_spin;
  logic          r_fault, r_both_d;
  phase_t        r_state, w_state_nxt;
  logic          w_filled, w_drained, w_viol, w_fault_nxt;
  logic          w_wash_en, w_spin_en, w_both;
  logic          w_unused;

  assign w_unused    = i_water_wash;
  assign w_filled    = (r_level == L_MAX);
  assign w_drained   = (r_level == '0);
  assign w_both      = i_fillvalve_on & i_drainvalve_on;
  assign w_wash_en   = i_motor_on & ~i_drainvalve_on & w_filled;
  assign w_spin_en   = i_motor_on & i_drainvalve_on;
  // Both valves open is only unsafe once it persists into a second cycle.
  assign w_viol      = ((i_motor_on | i_fillvalve_on) & ~i_doorlock)
                     | (w_both & r_both_d)
                     | (i_motor_on & ~i_drainvalve_on & w_drained);
  assign w_fault_nxt = r_fault | w_viol;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_level <= '0;
    end else if (!r_fault) begin
      if (i_fillvalve_on & ~i_drainvalve_on & i_doorlock & ~w_filled)
        r_level <= r_level + 1'b1;
      else if (i_drainvalve_on & ~i_fillvalve_on & ~w_drained)
        r_level <= r_level - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_det  <= '0;
      r_wash <= '0;
      r_spin <= '0;
    end else if (!r_fault) begin
      r_det  <= !i_soap_wash ? '0 : (r_det  == D_MAX) ? r_det  : r_det  + 1'b1;
      r_wash <= !w_wash_en   ? '0 : (r_wash == W_MAX) ? r_wash : r_wash + 1'b1;
      r_spin <= !w_spin_en   ? '0 : (r_spin == S_MAX) ? r_spin : r_spin + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_fault  <= 1'b0;
      r_both_d <= 1'b0;
      r_state  <= PH_IDLE;
    end else begin
      r_fault  <= w_fault_nxt;
      r_both_d <= w_both;
      r_state  <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = PH_IDLE;
    if (w_fault_nxt)            w_state_nxt = PH_FAULT;
    else if (w_spin_en)         w_state_nxt = PH_SPIN;
    else if (i_motor_on)        w_state_nxt = PH_WASH;
    else if (i_drainvalve_on)   w_state_nxt = PH_DRAIN;
    else if (i_fillvalve_on)    w_state_nxt = PH_FILL;
    else if (i_soap_wash)       w_state_nxt = PH_SOAP;
  end

  always_comb begin
    o_phase         = r_state;
    o_fault         = r_fault;
    o_filled        = w_filled;
    o_drained       = w_drained;
    o_detergent     = ~r_fault & (r_det  == D_MAX);
    o_cycletime_out = ~r_fault & (r_wash == W_MAX);
    o_spintime_out  = ~r_fault & (r_spin == S_MAX);
  end

endmodule
